ocs_slot_sequencer: RTL and testbench

- Parametrised successor to the 1-bit OCS slot-id generator inside the OCS controller.
- Waits for all enabled ToR control links to be stably up, then broadcasts a start command.
- Cycles through P_SLOT_NUM OCS slots: SLOT phase, then a reconfiguration (CONFIG) phase. Each new slot is announced by a per-channel time-sync request with a valid/ready handshake.
- Drives the OCS models' slot id and the per-ToR sync/start requests to the control-channel framers.

---
 rtl/ocs_slot_sequencer_if.sv | 17 +
 rtl/ocs_slot_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ocs_slot_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ocs_slot_sequencer_if.sv
`default_nettype none
// ============================================================================
// ocs_slot_sequencer_if : per-channel time-sync request bundle (valid/ready)
// Rev 1.0
// ============================================================================
interface ocs_slot_sequencer_if #(
  parameter int P_CHANNEL_NUM = 8,
  parameter int P_SLOT_W      = 1
);
  logic [P_CHANNEL_NUM-1:0] sync_valid;
  logic [P_CHANNEL_NUM-1:0] sync_ready;
  logic [P_SLOT_W-1:0]      sync_slot_id;

  modport master (output sync_valid, output sync_slot_id, input sync_ready);
  modport slave  (input sync_valid, input sync_slot_id, output sync_ready);
endinterface
`default_nettype wire

// File: rtl/ocs_slot_sequencer.sv
`default_nettype none
// ============================================================================
// ocs_slot_sequencer : link-gated OCS slot/config phase sequencer with sync
// Rev 1.0
// ============================================================================
module ocs_slot_sequencer #(
  parameter int          P_CHANNEL_NUM  = 8,
  parameter int          P_SLOT_NUM     = 2,
  parameter int          P_SLOT_W       = $clog2(P_SLOT_NUM),
  parameter logic [31:0] P_SLOT_LEN     = 32'h0000_0708,
  parameter logic [31:0] P_CONFIG_DELAY = 32'h0000_007D,
  parameter logic [15:0] P_LINK_STABLE  = 16'd256
) (
  input  wire logic                     i_clk,
  input  wire logic                     i_rst_n,
  input  wire logic                     i_enable,
  input  wire logic [P_CHANNEL_NUM-1:0] i_chan_mask,
  input  wire logic [P_CHANNEL_NUM-1:0] i_link_up,
  input  wire logic                     i_cfg_update,
  input  wire logic [31:0]              i_slot_len,
  input  wire logic [31:0]              i_cfg_delay,
  output logic      [P_SLOT_W-1:0]      o_slot_id,
  output logic                          o_cfg_active,
  output logic                          o_running,
  output logic                          o_sim_start,
  output logic                          o_slot_start,
  output logic                          o_sync_overrun,
  output logic                          o_link_err,
  ocs_slot_sequencer_if.master          sync
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINK = 3'd1,
    ST_START     = 3'd2,
    ST_SLOT      = 3'd3,
    ST_CONFIG    = 3'd4
  } state_t;

  state_t                   r_state;
  logic [P_CHANNEL_NUM-1:0] r_mask;
  logic [P_CHANNEL_NUM-1:0] r_sync_valid;
  logic [P_SLOT_W-1:0]      r_slot_id;
  logic [P_SLOT_W-1:0]      r_sync_slot_id;
  logic [15:0]              r_stable;
  logic [31:0]              r_cnt;
  logic [31:0]              r_slot_len;
  logic [31:0]              r_cfg_delay;
  logic [31:0]              r_shd_slot_len;
  logic [31:0]              r_shd_cfg_delay;
  logic                     r_cfg_active;
  logic                     r_running;
  logic                     r_sim_start;
  logic                     r_slot_start;
  logic                     r_sync_overrun;
  logic                     r_link_err;

  logic                     w_link_ok;
  logic                     w_slot_last;
  logic                     w_cfg_last;
  logic [P_CHANNEL_NUM-1:0] w_sync_pending;
  logic [P_SLOT_W-1:0]      w_slot_id_next;

  assign w_link_ok      = ((i_link_up & r_mask) == r_mask);
  assign w_slot_last    = (r_cnt == r_slot_len - 32'd1);
  assign w_cfg_last     = (r_cnt == r_cfg_delay - 32'd1);
  // Bits still outstanding after this cycle's transfers.
  assign w_sync_pending = r_sync_valid & ~sync.sync_ready;
  assign w_slot_id_next = (r_slot_id == P_SLOT_W'(P_SLOT_NUM - 1)) ? '0
                                                                   : r_slot_id + P_SLOT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_mask          <= '0;
      r_sync_valid    <= '0;
      r_slot_id       <= '0;
      r_sync_slot_id  <= '0;
      r_stable        <= '0;
      r_cnt           <= '0;
      r_slot_len      <= P_SLOT_LEN;
      r_cfg_delay     <= P_CONFIG_DELAY;
      r_shd_slot_len  <= P_SLOT_LEN;
      r_shd_cfg_delay <= P_CONFIG_DELAY;
      r_cfg_active    <= 1'b0;
      r_running       <= 1'b0;
      r_sim_start     <= 1'b0;
      r_slot_start    <= 1'b0;
      r_sync_overrun  <= 1'b0;
      r_link_err      <= 1'b0;
    end else begin
      r_sim_start    <= 1'b0;
      r_slot_start   <= 1'b0;
      r_sync_overrun <= 1'b0;
      r_link_err     <= 1'b0;
      r_sync_valid   <= w_sync_pending;

      if (i_cfg_update) begin
        if (i_slot_len >= 32'd2) r_shd_slot_len <= i_slot_len;
        if (i_cfg_delay != 32'd0) r_shd_cfg_delay <= i_cfg_delay;
      end

      if (!i_enable) begin
        r_state        <= ST_IDLE;
        r_stable       <= '0;
        r_cnt          <= '0;
        r_slot_id      <= '0;
        r_sync_slot_id <= '0;
        r_sync_valid   <= '0;
        r_cfg_active   <= 1'b0;
        r_running      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_mask   <= i_chan_mask;
            r_stable <= '0;
            r_state  <= ST_WAIT_LINK;
          end
          ST_WAIT_LINK: begin
            r_mask <= i_chan_mask;
            // An empty mask is never treated as "all links up".
            if (w_link_ok && (|r_mask)) begin
              if (r_stable == P_LINK_STABLE - 16'd1) begin
                r_stable <= '0;
                r_state  <= ST_START;
              end else begin
                r_stable <= r_stable + 16'd1;
              end
            end else begin
              r_stable <= '0;
            end
          end
          ST_START: begin
            r_state        <= ST_SLOT;
            r_cnt          <= '0;
            r_slot_id      <= '0;
            r_running      <= 1'b1;
            r_sim_start    <= 1'b1;
            r_slot_start   <= 1'b1;
            r_sync_valid   <= r_mask;
            r_sync_slot_id <= '0;
          end
          ST_SLOT, ST_CONFIG: begin
            if (!w_link_ok) begin
              r_link_err     <= 1'b1;
              r_state        <= ST_WAIT_LINK;
              r_cnt          <= '0;
              r_stable       <= '0;
              r_slot_id      <= '0;
              r_sync_slot_id <= '0;
              r_sync_valid   <= '0;
              r_cfg_active   <= 1'b0;
              r_running      <= 1'b0;
            end else if (r_state == ST_SLOT) begin
              if (w_slot_last) begin
                // Slot id advances on CONFIG entry so the OCS switches during CONFIG.
                r_state      <= ST_CONFIG;
                r_cnt        <= '0;
                r_slot_id    <= w_slot_id_next;
                r_cfg_active <= 1'b1;
                r_slot_len   <= r_shd_slot_len;
                r_cfg_delay  <= r_shd_cfg_delay;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end else begin
              if (w_cfg_last) begin
                r_state        <= ST_SLOT;
                r_cnt          <= '0;
                r_cfg_active   <= 1'b0;
                r_slot_start   <= 1'b1;
                r_sync_valid   <= r_mask;
                r_sync_slot_id <= r_slot_id;
                r_sync_overrun <= |w_sync_pending;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_slot_id         = r_slot_id;
  assign o_cfg_active      = r_cfg_active;
  assign o_running         = r_running;
  assign o_sim_start       = r_sim_start;
  assign o_slot_start      = r_slot_start;
  assign o_sync_overrun    = r_sync_overrun;
  assign o_link_err        = r_link_err;
  assign sync.sync_valid   = r_sync_valid;
  assign sync.sync_slot_id = r_sync_slot_id;

endmodule
`default_nettype wire

// File: tb/tb_ocs_slot_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ocs_slot_sequencer : scoreboard bench for the OCS slot sequencer
// Rev 1.0
// ============================================================================
module tb_ocs_slot_sequencer;

  localparam int C_SLOTS = 3;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        enable     = 1'b0;
  logic        cfg_update = 1'b0;
  logic [7:0]  chan_mask  = 8'h00;
  logic [7:0]  link_up    = 8'h00;
  logic [31:0] slot_len   = 32'd0;
  logic [31:0] cfg_delay  = 32'd0;
  logic [1:0]  slot_id;
  logic        cfg_active, running, sim_start, slot_start, sync_overrun, link_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         sim;
    bit         ovr;
    int         id;
    logic [7:0] valid;
    int         gap;
    int         cfg;
  } exp_t;

  exp_t sb[$];

  ocs_slot_sequencer_if #(.P_CHANNEL_NUM(8), .P_SLOT_W(2)) sync_bus ();

  ocs_slot_sequencer #(
    .P_CHANNEL_NUM (8),
    .P_SLOT_NUM    (C_SLOTS),
    .P_SLOT_W      (2),
    .P_SLOT_LEN    (32'd20),
    .P_CONFIG_DELAY(32'd5),
    .P_LINK_STABLE (16'd4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_chan_mask   (chan_mask),
    .i_link_up     (link_up),
    .i_cfg_update  (cfg_update),
    .i_slot_len    (slot_len),
    .i_cfg_delay   (cfg_delay),
    .o_slot_id     (slot_id),
    .o_cfg_active  (cfg_active),
    .o_running     (running),
    .o_sim_start   (sim_start),
    .o_slot_start  (slot_start),
    .o_sync_overrun(sync_overrun),
    .o_link_err    (link_err),
    .sync          (sync_bus)
  );

  always #5 clk = ~clk;

  wire [17:0] outs = {slot_id, cfg_active, running, sim_start, slot_start,
                      sync_overrun, link_err, sync_bus.sync_valid, sync_bus.sync_slot_id};

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input bit sim, input bit ovr, input int id,
                          input logic [7:0] v, input int gap, input int cfg);
    exp_t e;
    e.sim = sim; e.ovr = ovr; e.id = id; e.valid = v; e.gap = gap; e.cfg = cfg;
    sb.push_back(e);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  // sel: 0 = slot_start, 1 = sim_start, else cfg_active
  task automatic wait_evt(input string tag, input int sel, input int max_cyc, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
      case (sel)
        0:       hit = slot_start;
        1:       hit = sim_start;
        default: hit = cfg_active;
      endcase
    end
    chk_eq({tag, "_tmo"}, 32'(hit), 32'd1);
  endtask

  initial begin : monitor
    int   since;
    int   cfg_cnt;
    int   last_id;
    bit   cfg_prev;
    exp_t e;
    since = 0; cfg_cnt = 0; last_id = 0; cfg_prev = 1'b0;
    forever begin
      @(negedge clk);
      since++;
      if (slot_start === 1'b1) begin
        chk_eq("sb_avail", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_eq("sim_start", 32'(sim_start), 32'(e.sim));
          chk_eq("overrun", 32'(sync_overrun), 32'(e.ovr));
          chk_eq("slot_id", 32'(slot_id), 32'(e.id));
          chk_eq("sync_slot_id", 32'(sync_bus.sync_slot_id), 32'(e.id));
          chk_eq("sync_valid", 32'(sync_bus.sync_valid), 32'(e.valid));
          chk_eq("running", 32'(running), 32'd1);
          if (e.gap != 0) chk_eq("slot_period", 32'(since), 32'(e.gap));
          if (e.cfg != 0) chk_eq("cfg_len", 32'(cfg_cnt), 32'(e.cfg));
          last_id = e.id;
        end
        since = 0;
      end
      if (cfg_active === 1'b1 && !cfg_prev)
        chk_eq("cfg_id", 32'(slot_id), 32'((last_id + 1) % C_SLOTS));
      cfg_prev = cfg_active;
      cfg_cnt  = (cfg_active === 1'b1) ? cfg_cnt + 1 : 0;
    end
  end

  initial begin : main
    int n;
    sync_bus.sync_ready = 8'hFF;
    #1 rst_n = 1'b0;
    #11;
    chk_eq("rst_outputs", 32'(outs), 32'd0);

    @(negedge clk); #1;
    rst_n     = 1'b1;
    chan_mask = 8'h00;
    link_up   = 8'hFF;
    enable    = 1'b1;
    step(12);
    chk_eq("zero_mask_idle", 32'(running), 32'd0);

    // Start-up: mask latched first, links come up afterwards.
    link_up   = 8'h00;
    chan_mask = 8'hFF;
    step(3);
    link_up = 8'hFF;
    push_exp(1, 0, 0, 8'hFF, 0, 0);
    wait_evt("startup", 1, 20, n);
    chk_eq("startup_lat", 32'(n), 32'd5);
    step(1);
    chk_eq("valid_clr", 32'(sync_bus.sync_valid), 32'd0);

    for (int k = 1; k <= 3; k++) begin
      push_exp(0, 0, k % C_SLOTS, 8'hFF, 25, 5);
      wait_evt("steady", 0, 40, n);
    end

    // Channel 3 withholds ready for a whole slot.
    sync_bus.sync_ready = 8'hF7;
    push_exp(0, 1, 1, 8'hFF, 25, 5);
    step(2);
    chk_eq("hs_pending", 32'(sync_bus.sync_valid), 32'h08);
    wait_evt("hs_ovr", 0, 40, n);
    sync_bus.sync_ready = 8'hFF;
    push_exp(0, 0, 2, 8'hFF, 25, 5);
    wait_evt("hs_ok", 0, 40, n);

    // Runtime update: slot 10 accepted, config 0 rejected.
    step(3);
    slot_len = 32'd10; cfg_delay = 32'd0; cfg_update = 1'b1;
    step(1);
    cfg_update = 1'b0;
    push_exp(0, 0, 0, 8'hFF, 25, 5);
    push_exp(0, 0, 1, 8'hFF, 15, 5);
    wait_evt("upd_a", 0, 40, n);
    wait_evt("upd_b", 0, 40, n);
    // Slot length 1 rejected, config 7 accepted.
    step(2);
    slot_len = 32'd1; cfg_delay = 32'd7; cfg_update = 1'b1;
    step(1);
    cfg_update = 1'b0;
    push_exp(0, 0, 2, 8'hFF, 17, 7);
    wait_evt("upd_c", 0, 40, n);
    push_exp(0, 0, 0, 8'hFF, 17, 7);
    wait_evt("upd_d", 0, 40, n);

    // Link 5 drops on the first CONFIG cycle (slot id now 1).
    wait_evt("ld_cfg", 2, 30, n);
    link_up = 8'hDF;
    step(1);
    chk_eq("ld_err", 32'(link_err), 32'd1);
    chk_eq("ld_id", 32'(slot_id), 32'd0);
    chk_eq("ld_cfg_active", 32'(cfg_active), 32'd0);
    chk_eq("ld_running", 32'(running), 32'd0);
    step(1);
    chk_eq("ld_err_pulse", 32'(link_err), 32'd0);
    step(2);
    link_up = 8'hFF;
    push_exp(1, 0, 0, 8'hFF, 0, 0);
    wait_evt("relink", 1, 20, n);
    chk_eq("relink_lat", 32'(n), 32'd5);
    push_exp(0, 0, 1, 8'hFF, 17, 7);
    wait_evt("retain", 0, 40, n);

    // Enable low together with a link drop: no link error.
    enable  = 1'b0;
    link_up = 8'hFE;
    step(1);
    chk_eq("dis_link_err", 32'(link_err), 32'd0);
    chk_eq("dis_running", 32'(running), 32'd0);
    chk_eq("dis_slot_id", 32'(slot_id), 32'd0);

    // Partial mask with links 4-7 down.
    chan_mask = 8'h0F;
    link_up   = 8'h0F;
    enable    = 1'b1;
    push_exp(1, 0, 0, 8'h0F, 0, 0);
    wait_evt("mask_su", 1, 20, n);
    chk_eq("mask_lat", 32'(n), 32'd6);
    push_exp(0, 0, 1, 8'h0F, 17, 7);
    wait_evt("mask_run", 0, 40, n);

    step(3);
    rst_n = 1'b0;
    #1;
    chk_eq("async_rst", 32'(outs), 32'd0);
    chk_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
